// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter (mem_arbiter).
// Round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_C = 1'b0;
  localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick for mem_arbiter: fixed C-over-D priority by default,
// round-robin on ties when MEM_ARB_RR_EN is defined.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic     c_req_i,
  input  logic     d_req_i,
`ifdef MEM_ARB_RR_EN
  input  port_id_t last_winner_i,
`endif
  output logic     valid_o,
  output port_id_t winner_o
);

  // NOTE: every output of an always_comb is given a value on every path
  // (here, up front) so no latch can be inferred.
  always_comb begin
    valid_o  = c_req_i | d_req_i;
    winner_o = PORT_C;
`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last goes first; a lone requester always wins.
    if (c_req_i && d_req_i) begin
      winner_o = (last_winner_i == PORT_C) ? PORT_D : PORT_C;
    end else if (d_req_i) begin
      winner_o = PORT_D;
    end
`else
    if (!c_req_i && d_req_i) begin
      winner_o = PORT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises port C (control unit) and port D (DMA/debug) onto one synchronous RAM.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking instead of C priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ack,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_e                state_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  port_id_t              winner_q;
  logic [DATA_WIDTH-1:0] c_hold_q;
  logic [DATA_WIDTH-1:0] d_hold_q;
  logic                  mem_enable_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  c_ack_q;
  logic                  d_ack_q;
  logic                  busy_q;

  logic                  grant_valid;
  port_id_t              grant_id;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

`ifdef MEM_ARB_RR_EN
  // Holds the last winner; resetting it to D hands the first tie to C.
  port_id_t rr_last_q;
`endif

  mem_arb_select u_select (
    .c_req_i       (c_req),
    .d_req_i       (d_req),
`ifdef MEM_ARB_RR_EN
    .last_winner_i (rr_last_q),
`endif
    .valid_o       (grant_valid),
    .winner_o      (grant_id)
  );

  always_comb begin
    we_d    = c_we;
    addr_d  = c_addr;
    wdata_d = c_wdata;
    if (grant_id == PORT_D) begin
      we_d    = d_we;
      addr_d  = d_addr;
      wdata_d = d_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      winner_q     <= PORT_C;
      c_hold_q     <= '0;
      d_hold_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      c_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= PORT_D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q      <= ACCESS;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            winner_q     <= grant_id;
            mem_enable_q <= 1'b1;
            mem_read_q   <= ~we_d;
            mem_write_q  <= we_d;
            busy_q       <= 1'b1;
`ifdef MEM_ARB_RR_EN
            rr_last_q    <= grant_id;
`endif
          end
        end
        ACCESS: begin
          state_q      <= DONE;
          mem_enable_q <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          c_ack_q      <= (winner_q == PORT_C);
          d_ack_q      <= (winner_q == PORT_D);
        end
        DONE: begin
          state_q <= IDLE;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          if (!we_q) begin
            if (winner_q == PORT_C) c_hold_q <= mem_rdata;
            else                    d_hold_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an abandoned write never reaches the RAM edge.
  assign mem_enable = mem_enable_q & ~reset;
  assign mem_read   = mem_read_q & ~reset;
  assign mem_write  = mem_write_q & ~reset;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign c_ack      = c_ack_q;
  assign d_ack      = d_ack_q;
  assign busy       = busy_q;

  assign c_rdata = (state_q == DONE && winner_q == PORT_C && !we_q) ? mem_rdata : c_hold_q;
  assign d_rdata = (state_q == DONE && winner_q == PORT_D && !we_q) ? mem_rdata : d_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 512x32 synchronous RAM.
// Tie expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_ack, d_ack;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_read, mem_write, mem_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic [DW-1:0] ram [512];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_ack      (c_ack),
    .c_rdata    (c_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // RAM model: write on the edge ending the strobe cycle, read data valid the next cycle.
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    if (mem_enable) begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    step();
    ld_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, busy},       32'd0);
    check({tag, "_c_ack"},  {31'd0, c_ack},      32'd0);
    check({tag, "_d_ack"},  {31'd0, d_ack},      32'd0);
    check({tag, "_en"},     {31'd0, mem_enable}, 32'd0);
    check({tag, "_rd"},     {31'd0, mem_read},   32'd0);
    check({tag, "_wr"},     {31'd0, mem_write},  32'd0);
    check({tag, "_addr"},   {23'd0, mem_addr},   32'd0);
    check({tag, "_wdata"},  mem_wdata,           32'd0);
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;

    // Power-on reset
    step(2);
    check_idle_outputs("rst");
    check("rst_c_rdata", c_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    step();

    // Single read on port C
    preload(9'h005, 32'hDEADBEEF);
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
    step();
    check("rd_n1_read",  {31'd0, mem_read},   32'd1);
    check("rd_n1_en",    {31'd0, mem_enable}, 32'd1);
    check("rd_n1_addr",  {23'd0, mem_addr},   32'h005);
    check("rd_n1_busy",  {31'd0, busy},       32'd1);
    check("rd_n1_ack",   {31'd0, c_ack},      32'd0);
    step();
    check("rd_n2_ack",   {31'd0, c_ack},      32'd1);
    check("rd_n2_dack",  {31'd0, d_ack},      32'd0);
    check("rd_n2_rdata", c_rdata,             32'hDEADBEEF);
    check("rd_n2_stb",   {31'd0, mem_enable}, 32'd0);
    c_req = 1'b0;
    step();
    check_idle_outputs("rd_n3");
    step(3);
    check("rd_n6_rdata", c_rdata, 32'hDEADBEEF);

    // Port D write then back-to-back read of 0x1FF
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1FF; d_wdata = 32'h12345678;
    step();
    check("dw_n1_wr",    {31'd0, mem_write}, 32'd1);
    check("dw_n1_rd",    {31'd0, mem_read},  32'd0);
    check("dw_n1_addr",  {23'd0, mem_addr},  32'h1FF);
    check("dw_n1_wdata", mem_wdata,          32'h12345678);
    step();
    check("dw_n2_ack",   {31'd0, d_ack},     32'd1);
    check("dw_n2_ram",   ram[9'h1FF],        32'h12345678);
    d_we = 1'b0;
    step();
    check("dr_n3_ack",   {31'd0, d_ack},     32'd0);
    step();
    check("dr_n4_rd",    {31'd0, mem_read},  32'd1);
    step();
    check("dr_n5_ack",   {31'd0, d_ack},     32'd1);
    check("dr_n5_rdata", d_rdata,            32'h12345678);
    d_req = 1'b0;
    step();
    check("dr_n6_rdata", d_rdata,            32'h12345678);
    check("dr_n6_crd",   c_rdata,            32'hDEADBEEF);

    // Address change during ACCESS is ignored
    preload(9'h001, 32'h11111111);
    preload(9'h002, 32'h22222222);
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h001;
    step();
    c_addr = 9'h002;
    #1;
    check("mid_n1_addr",  {23'd0, mem_addr}, 32'h001);
    step();
    check("mid_n2_ack",   {31'd0, c_ack},    32'd1);
    check("mid_n2_rdata", c_rdata,           32'h11111111);
    c_req = 1'b0;
    step(2);

    // Reset during a port-D write to 0x010
    preload(9'h010, 32'hA5A5A5A5);
    preload(9'h020, 32'hC0C0C0C0);
    preload(9'h021, 32'hD0D0D0D0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'hFFFF0000;
    step();
    check("rma_n1_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("rma_n1_wr_masked", {31'd0, mem_write}, 32'd0);
    step();
    check_idle_outputs("rma_r1");
    check("rma_r1_c_rdata", c_rdata, 32'd0);
    check("rma_r1_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    step();
    check_idle_outputs("rma_r2");
    reset = 1'b0;
    step(3);
    check("rma_post_dack", {31'd0, d_ack}, 32'd0);
    check("rma_ram",       ram[9'h010],    32'hA5A5A5A5);

    // Both ports request continuously: four accesses
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h021;
    for (int k = 1; k <= 12; k++) begin
      logic ack_slot;
      logic c_turn;
      step();
      ack_slot = (k % 3 == 2);
      c_turn   = RR ? (((k - 2) / 3) % 2 == 0) : 1'b1;
      check($sformatf("tie_k%0d_c_ack", k), {31'd0, c_ack}, {31'd0, ack_slot && c_turn});
      check($sformatf("tie_k%0d_d_ack", k), {31'd0, d_ack}, {31'd0, ack_slot && !c_turn});
      check($sformatf("tie_k%0d_c_rdata", k), c_rdata, (k >= 2) ? 32'hC0C0C0C0 : 32'd0);
      check($sformatf("tie_k%0d_d_rdata", k), d_rdata,
            (RR && k >= 5) ? 32'hD0D0D0D0 : 32'd0);
    end
    c_req = 1'b0; d_req = 1'b0;
    step(3);
    check_idle_outputs("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
